// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
package dcache_pkg;

  // Default cache line / memory bus width (eight 32-bit words)
  localparam int DEFAULT_LINE_BITS = 256;

  // Byte-offset field width inside a line
  localparam int OFFSET_W = 5;

  // CPU word width
  localparam int WORD_BITS = 32;

  // Miss-handling controller states
  typedef enum logic [2:0] {
    IDLE,
    MISS,
    WRITEBACK,
    READMISS,
    READMISSOK
  } state_t;

endpackage

// File: rtl/dcache_sram.sv
// Tag / valid / dirty / data storage for the data cache.
// Asynchronous read of one line, one synchronous write port that always
// marks the written line valid. Valid and dirty clear on reset; tag and data
// storage is not reset because it is qualified by the valid bits.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int LINE_BITS = DEFAULT_LINE_BITS,
  parameter int IDX_W     = 4,
  parameter int TAG_W     = 23
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic                 wr_dirty,
  input  logic [LINE_BITS-1:0] wr_line,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [TAG_W-1:0]     rd_tag,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [LINE_BITS-1:0] rd_line
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] line_q [NUM_LINES];

  // Status bits: cleared on reset, a write installs a valid line with the given dirty state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      dirty_q[wr_idx] <= wr_dirty;
    end
  end

  // Tag and line payload storage, written only outside reset
  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i) begin
      tag_q[wr_idx]  <= wr_tag;
      line_q[wr_idx] <= wr_line;
    end
  end

  assign rd_tag   = tag_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_line  = line_q[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits are served combinationally; misses stall the pipeline while an
// optional dirty-victim write-back and a line refill run over the memory bus.
// Optional feature: define DCACHE_STATS_EN to add saturating hit/miss counters
// on hit_cnt_o / miss_cnt_o.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int LINE_BITS = DEFAULT_LINE_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  input  logic                 cpu_MemRead_i,
  input  logic                 cpu_MemWrite_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
`endif
);

  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = 32 - OFFSET_W - IDX_W;
  localparam int WSEL_W = $clog2(LINE_BITS / WORD_BITS);

  state_t state_q, state_d;

  logic              req;
  logic              is_store;
  logic [IDX_W-1:0]  cpu_idx;
  logic [TAG_W-1:0]  cpu_tag;
  logic [WSEL_W-1:0] wsel;
  logic              busy;
  logic              hit;
  logic              miss;

  logic [IDX_W-1:0]  miss_idx_q;
  logic [TAG_W-1:0]  miss_tag_q;

  logic [IDX_W-1:0]     rd_idx;
  logic [TAG_W-1:0]     rd_tag;
  logic                 rd_valid;
  logic                 rd_dirty;
  logic [LINE_BITS-1:0] rd_line;
  logic [LINE_BITS-1:0] store_line;

  logic                 wr_en;
  logic [IDX_W-1:0]     wr_idx;
  logic [TAG_W-1:0]     wr_tag;
  logic                 wr_dirty;
  logic [LINE_BITS-1:0] wr_line;

  logic unused_addr_bits;

  // A simultaneous read and write request is handled as a store
  assign req      = cpu_MemRead_i | cpu_MemWrite_i;
  assign is_store = cpu_MemWrite_i;
  assign cpu_idx  = cpu_addr_i[OFFSET_W +: IDX_W];
  assign cpu_tag  = cpu_addr_i[31 -: TAG_W];
  assign wsel     = cpu_addr_i[2 +: WSEL_W];

  assign unused_addr_bits = ^cpu_addr_i[1:0];

  // While the miss engine runs, the array is addressed by the latched miss so
  // the memory bus stays stable even if the CPU request changes or drops
  assign busy   = (state_q == MISS) || (state_q == WRITEBACK) || (state_q == READMISS);
  assign rd_idx = busy ? miss_idx_q : cpu_idx;

  assign hit         = req && !busy && rd_valid && (rd_tag == cpu_tag);
  assign miss        = req && !hit && (state_q == IDLE);
  assign cpu_stall_o = req && !hit;
  assign cpu_data_o  = rd_line[int'(wsel) * WORD_BITS +: WORD_BITS];
  assign mem_data_o  = rd_line;

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .LINE_BITS (LINE_BITS),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_sram (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_tag   (wr_tag),
    .wr_dirty (wr_dirty),
    .wr_line  (wr_line),
    .rd_idx   (rd_idx),
    .rd_tag   (rd_tag),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_line  (rd_line)
  );

  // Merge the store word into the currently addressed line
  always_comb begin
    store_line = rd_line;
    store_line[int'(wsel) * WORD_BITS +: WORD_BITS] = cpu_data_i;
  end

  // Capture the missing address on the cycle the miss is detected
  always_ff @(posedge clk_i) begin
    if (miss) begin
      miss_idx_q <= cpu_idx;
      miss_tag_q <= cpu_tag;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: write back a dirty victim first, then refill the line
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (miss) state_d = MISS;
      MISS:       state_d = (rd_valid && rd_dirty) ? WRITEBACK : READMISS;
      WRITEBACK:  if (mem_ack_i) state_d = READMISS;
      READMISS:   if (mem_ack_i) state_d = READMISSOK;
      READMISSOK: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // FSM outputs: memory bus requests and the single array write port
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    wr_en        = 1'b0;
    wr_idx       = cpu_idx;
    wr_tag       = cpu_tag;
    wr_dirty     = 1'b0;
    wr_line      = store_line;
    case (state_q)
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {rd_tag, miss_idx_q, {OFFSET_W{1'b0}}};
      end
      READMISS: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {miss_tag_q, miss_idx_q, {OFFSET_W{1'b0}}};
        if (mem_ack_i && !rst_i) begin
          wr_en    = 1'b1;
          wr_idx   = miss_idx_q;
          wr_tag   = miss_tag_q;
          wr_dirty = 1'b0;
          wr_line  = mem_data_i;
        end
      end
      IDLE, READMISSOK: begin
        if (hit && is_store && !rst_i) begin
          wr_en    = 1'b1;
          wr_dirty = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

`ifdef DCACHE_STATS_EN
  // Saturating counters: hits that needed no refill, and miss detections
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit && (state_q == IDLE) && (hit_cnt_o != '1)) begin
        hit_cnt_o <= hit_cnt_o + 32'd1;
      end
      if (miss && (miss_cnt_o != '1)) begin
        miss_cnt_o <= miss_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule
